// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction prefetch queue with req/ack fetch, redirect flush and NOP bubbles.
// Define IF_PFQ_STATS_EN to add saturating stat_flush / stat_empty counters.
module if_prefetch_queue #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(16'h0800)
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     stall,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   count
`ifdef IF_PFQ_STATS_EN
    ,
    output logic [15:0]              stat_flush,
    output logic [15:0]              stat_empty
`endif
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, mem_addr_n;
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW+1:0] occ;
    logic push, pop, issue;
    assign pop = out_valid && !stall && !redirect;
    assign push = state == BUSY && mem_ack && !redirect;
    assign occ = {1'b0, count} + {{(PW+1){1'b0}}, pop};
    // A redirect empties the queue, so it may start the refetch at once.
    assign issue = state == IDLE && (redirect || occ < (PW+2)'(DEPTH));
    assign out_valid = count != '0;
    assign out_instr = out_valid ? instr_q[rd_ptr] : NOP_INSTR;
    assign out_pc = out_valid ? pc_q[rd_ptr] + ADDR_W'(1) : '0;
    always_comb begin
        state_n = state;
        mem_addr_n = mem_addr;
        fetch_pc_n = redirect ? redirect_pc : push ? fetch_pc + ADDR_W'(1) : fetch_pc;
        case (state)
            IDLE: if (issue) begin
                state_n = BUSY;
                mem_addr_n = redirect ? redirect_pc : fetch_pc;
            end
            BUSY: state_n = mem_ack ? IDLE : redirect ? DROP : BUSY;
            default: state_n = mem_ack ? IDLE : DROP;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            mem_req <= state_n != IDLE;
            mem_addr <= mem_addr_n;
            fetch_pc <= fetch_pc_n;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_q[wr_ptr] <= fetch_pc;
            instr_q[wr_ptr] <= mem_rdata;
        end
    end
`ifdef IF_PFQ_STATS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stat_flush <= '0;
            stat_empty <= '0;
        end else begin
            if (redirect && stat_flush != 16'hFFFF) stat_flush <= stat_flush + 16'd1;
            if (!out_valid && !stall && stat_empty != 16'hFFFF) stat_empty <= stat_empty + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: random-latency memory model plus expected-PC-stream scoreboard.
`timescale 1ns/1ps
module tb_if_prefetch_queue;
    localparam int DEPTH = 4;
    logic CLK = 1'b0, RST = 1'b0;
    logic mem_req, mem_ack = 1'b0, redirect = 1'b0, stall = 1'b0, out_valid;
    logic [15:0] mem_addr, out_instr, out_pc;
    logic [15:0] mem_rdata = '0, redirect_pc = '0;
    logic [2:0] count;
`ifdef IF_PFQ_STATS_EN
    logic [15:0] stat_flush, stat_empty;
`endif
    int tests = 0, fails = 0;
    int lat_min = 0, lat_max = 0, red_seen = 0;
    bit mem_hang = 1'b0;
    logic [15:0] exp_q[$];
    always #5 CLK = ~CLK;

    if_prefetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .count(count)
`ifdef IF_PFQ_STATS_EN
        , .stat_flush(stat_flush), .stat_empty(stat_empty)
`endif
    );

    function automatic logic [15:0] ram(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h3C5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery order after a (re)start at base: base, base+1, ... mod 2^16.
    task automatic load_stream(input logic [15:0] base);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(base + 16'(i));
    endtask

    // Memory: variable latency, ack may land in the first request cycle.
    initial begin
        bit pending = 1'b0;
        int wait_cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                pending = 1'b0;
            end else if (mem_req && !mem_hang) begin
                if (!pending) begin
                    pending = 1'b1;
                    wait_cnt = $urandom_range(lat_max, lat_min);
                end
                if (wait_cnt == 0) mem_ack = 1'b1;
                else wait_cnt--;
            end
            mem_rdata = mem_ack ? ram(mem_addr) : 16'($urandom);
        end
    end

    // Monitor: pops the expected stream whenever the head is consumed.
    logic prev_redirect = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;
    always @(negedge CLK) begin
        logic [15:0] pc;
        if (RST) begin
            check("valid_vs_count", {31'd0, out_valid}, {31'd0, count != 3'd0});
            check("count_bound", {31'd0, count <= 3'(DEPTH)}, 32'd1);
            if (prev_redirect) check("flush_count", {29'd0, count}, 32'd0);
            if (prev_req && !prev_ack && mem_req) check("addr_stable", {16'd0, mem_addr}, {16'd0, prev_addr});
            if (!out_valid) begin
                check("nop_instr", {16'd0, out_instr}, 32'h0800);
                check("nop_pc", {16'd0, out_pc}, 32'd0);
            end else if (!stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stream_overrun: got pc+1 %h expected no output", out_pc);
                end else begin
                    pc = exp_q.pop_front();
                    check("out_pc", {16'd0, out_pc}, {16'd0, 16'(pc + 16'd1)});
                    check("out_instr", {16'd0, out_instr}, {16'd0, ram(pc)});
                end
            end
            if (redirect) red_seen++;
        end
        prev_redirect = redirect && RST;
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_addr = mem_addr;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_req(input logic want, input string name);
        int n = 0;
        while (mem_req !== want && n < 60) begin
            tick();
            n++;
        end
        if (mem_req !== want) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout got mem_req %b expected %b", name, mem_req, want);
        end
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        load_stream(pc);
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        int n, since;
`ifdef IF_PFQ_STATS_EN
        logic [15:0] f0;
`endif
        load_stream(16'h0000);
        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", {16'd0, out_instr}, 32'h0800);
        check("rst_pc", {16'd0, out_pc}, 32'd0);
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        wait_req(1'b1, "first_req");
        check("first_addr", {16'd0, mem_addr}, 32'd0);
        repeat (30) tick();

        stall = 1'b1;
        repeat (20) tick();
        check("stall_full", {29'd0, count}, DEPTH);
        check("stall_req", {31'd0, mem_req}, 32'd0);
        stall = 1'b0;
        repeat (20) tick();

        lat_min = 3; lat_max = 3;
        n = 0;
        while (!(mem_req && !mem_ack) && n < 60) begin tick(); n++; end
        check("busy_found", {31'd0, mem_req && !mem_ack}, 32'd1);
        do_redirect(16'h0040);
        wait_req(1'b0, "drop_done");
        wait_req(1'b1, "refetch_40");
        check("refetch_addr_40", {16'd0, mem_addr}, 32'h0040);
        repeat (25) tick();

        lat_min = 1; lat_max = 3;
        n = 0;
        while (!mem_ack && n < 60) begin tick(); n++; end
        check("ack_found", {31'd0, mem_ack}, 32'd1);
        do_redirect(16'h0100);
        check("ack_flush_valid", {31'd0, out_valid}, 32'd0);
        wait_req(1'b1, "refetch_100");
        check("refetch_addr_100", {16'd0, mem_addr}, 32'h0100);
        repeat (25) tick();

        lat_min = 0; lat_max = 0;
        do_redirect(16'hFFFE);
        repeat (20) tick();

        lat_min = 0; lat_max = 4;
        since = 0;
        for (int c = 0; c < 2000; c++) begin
            stall = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 19) == 0 || since >= 120) begin
                since = 0;
                stall = 1'b0;
                do_redirect($urandom_range(0, 7) == 0 ? 16'hFFFD : 16'($urandom));
            end else begin
                since++;
                tick();
            end
        end
        stall = 1'b0;
        repeat (5) tick();

`ifdef IF_PFQ_STATS_EN
        check("stat_flush_total", {16'd0, stat_flush}, red_seen > 65535 ? 32'hFFFF : 32'(red_seen));
        f0 = stat_flush;
        for (int i = 0; i < 3; i++) begin do_redirect(16'h0300); tick(); end
        check("stat_flush_3", {16'd0, 16'(stat_flush - f0)}, 32'd3);
        mem_hang = 1'b1;
        do_redirect(16'h0200);
        repeat (65540) tick();
        check("stat_empty_sat", {16'd0, stat_empty}, 32'hFFFF);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
